// File: rtl/mux_stream_n_pkg.sv
// Shared constants and helpers for the mux_stream_n stream multiplexer.
package mux_stream_n_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_stream_n_rr_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr_i (with wrap) wins.
module rr_arbiter #(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [NCH-1:0]  gnt_o,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_vld_o
);

  always_comb begin
    int c;
    c         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      c = (int'(ptr_i) + k) % NCH;
      if (!gnt_vld_o && req_i[c]) begin
        gnt_o[c]  = 1'b1;
        gnt_idx_o = SELW'(c);
        gnt_vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready stream multiplexer with one registered output stage;
// channel chosen by external sel (MODE_SEL) or round-robin arbitration (MODE_RR).
module mux_stream_n
  import mux_stream_n_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  NCH   = 4,
  parameter int  MODE  = MODE_SEL,
  localparam int SELW  = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic             load_en;
  logic             xfer;
  logic [NCH-1:0]   gnt_oh;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_vld;
  logic [WIDTH-1:0] gnt_data;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;

  if (MODE == MODE_RR) begin : g_rr
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            sel_unused;

    assign sel_unused = ^sel;

    rr_arbiter #(.NCH(NCH), .SELW(SELW)) u_arb (
      .req_i     (in_valid),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
    );

    // Pointer advances past the winner only when its beat is actually taken.
    always_comb begin
      ptr_d = ptr_q;
      if (xfer) begin
        ptr_d = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + SELW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
    end
  end else begin : g_sel
    // Out-of-range sel matches no channel, so it simply never grants.
    always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          gnt_oh[i] = 1'b1;
          gnt_idx   = SELW'(i);
          gnt_vld   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(gnt_idx) == i) gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign load_en  = ~out_valid_q | out_ready;
  assign xfer     = rst_n & load_en & gnt_vld;
  assign in_ready = gnt_oh & {NCH{rst_n & load_en}};

  // Output stage: a new beat replaces a draining one with no bubble.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (xfer) begin
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_n.sv
// Scoreboard bench for mux_stream_n: round-robin (NCH 4), external select (NCH 4 and NCH 3).
module tb_mux_stream_n;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] ch;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: MODE 1, NCH 4
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [1:0]  a_sel, a_out_ch;
  logic [7:0]  a_out_data;
  logic        a_out_valid, a_out_ready;
  // DUT B: MODE 0, NCH 4
  logic [31:0] b_in_data;
  logic [3:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_out_ch;
  logic [7:0]  b_out_data;
  logic        b_out_valid, b_out_ready;
  // DUT C: MODE 0, NCH 3
  logic [23:0] c_in_data;
  logic [2:0]  c_in_valid, c_in_ready;
  logic [1:0]  c_sel, c_out_ch;
  logic [7:0]  c_out_data;
  logic        c_out_valid, c_out_ready;

  mux_stream_n #(.WIDTH(8), .NCH(4), .MODE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  mux_stream_n #(.WIDTH(8), .NCH(4), .MODE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  mux_stream_n #(.WIDTH(8), .NCH(3), .MODE(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data), .out_ch(c_out_ch),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  int    tests = 0;
  int    fails = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t ea, eb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic beat_t mk(input logic [7:0] d, input logic [1:0] ch);
    beat_t b;
    b.d  = d;
    b.ch = ch;
    return b;
  endfunction

  // Monitors: an output beat is consumed at the edge following a negedge where valid & ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_beat: got data=%h ch=%0d, required no beat", a_out_data, a_out_ch);
      end else begin
        ea = qa.pop_front();
        chk("a_out_data", 32'(a_out_data), 32'(ea.d));
        chk("a_out_ch", 32'(a_out_ch), 32'(ea.ch));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_beat: got data=%h ch=%0d, required no beat", b_out_data, b_out_ch);
      end else begin
        eb = qb.pop_front();
        chk("b_out_data", 32'(b_out_data), 32'(eb.d));
        chk("b_out_ch", 32'(b_out_ch), 32'(eb.ch));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    a_in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    a_in_valid  = 4'b1111;
    a_sel       = 2'd0;
    a_out_ready = 1'b1;
    b_in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    b_in_valid  = 4'b0000;
    b_sel       = 2'd0;
    b_out_ready = 1'b1;
    c_in_data   = {8'h33, 8'h22, 8'h11};
    c_in_valid  = 3'b000;
    c_sel       = 2'd0;
    c_out_ready = 1'b1;

    // Reset with all channels requesting
    step();
    step();
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    chk("rst_out_ch", 32'(a_out_ch), 32'd0);

    // Round-robin over all four channels
    rst_n = 1'b1;
    #1;
    chk("rr_first_in_ready", 32'(a_in_ready), 32'b0001);
    qa.push_back(mk(8'h11, 2'd0));
    qa.push_back(mk(8'h22, 2'd1));
    qa.push_back(mk(8'h33, 2'd2));
    qa.push_back(mk(8'h44, 2'd3));
    qa.push_back(mk(8'h11, 2'd0));
    for (int i = 0; i < 5; i++) step();

    // Backpressure: beat 11/0 held, ptr parked at 1
    a_out_ready = 1'b0;
    #1;
    chk("stall_in_ready_now", 32'(a_in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_out_valid", 32'(a_out_valid), 32'd1);
      chk("stall_out_data", 32'(a_out_data), 32'h11);
      chk("stall_out_ch", 32'(a_out_ch), 32'd0);
      chk("stall_in_ready", 32'(a_in_ready), 32'd0);
    end
    a_out_ready = 1'b1;
    #1;
    chk("post_stall_in_ready", 32'(a_in_ready), 32'b0010);
    qa.push_back(mk(8'h22, 2'd1));
    step();

    // Sparse requests 3 and 1 with ptr now at 2
    a_in_valid = 4'b1010;
    #1;
    chk("sparse_in_ready", 32'(a_in_ready), 32'b1000);
    qa.push_back(mk(8'h44, 2'd3));
    qa.push_back(mk(8'h22, 2'd1));
    qa.push_back(mk(8'h44, 2'd3));
    for (int i = 0; i < 3; i++) step();
    a_in_valid = 4'b0000;
    step();
    step();
    chk("a_drained_valid", 32'(a_out_valid), 32'd0);
    chk("a_queue_empty", 32'(qa.size()), 32'd0);

    // Reset while a beat is stalled: the beat must never emerge
    a_in_valid  = 4'b0001;
    a_out_ready = 1'b0;
    step();
    chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
    rst_n      = 1'b0;
    a_in_valid = 4'b0000;
    #1;
    chk("in_rst_in_ready", 32'(a_in_ready), 32'd0);
    step();
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_data", 32'(a_out_data), 32'd0);
    rst_n       = 1'b1;
    a_out_ready = 1'b1;
    step();
    step();
    chk("post_rst_valid", 32'(a_out_valid), 32'd0);

    // MODE 0, NCH 4
    b_sel      = 2'd2;
    b_in_valid = 4'b0100;
    #1;
    chk("b_sel2_in_ready", 32'(b_in_ready), 32'b0100);
    qb.push_back(mk(8'h33, 2'd2));
    step();
    chk("b_sel2_out_ch", 32'(b_out_ch), 32'd2);
    b_in_valid = 4'b1011;
    #1;
    chk("b_sel2_nogrant", 32'(b_in_ready), 32'd0);
    step();
    chk("b_nogrant_valid", 32'(b_out_valid), 32'd0);
    b_sel = 2'd0;
    #1;
    chk("b_sel0_in_ready", 32'(b_in_ready), 32'b0001);
    qb.push_back(mk(8'h11, 2'd0));
    step();
    b_in_valid = 4'b0000;
    step();
    chk("b_queue_empty", 32'(qb.size()), 32'd0);

    // MODE 0, NCH 3: sel beyond the last channel
    c_sel      = 2'd3;
    c_in_valid = 3'b111;
    #1;
    chk("c_sel3_in_ready", 32'(c_in_ready), 32'd0);
    step();
    chk("c_sel3_valid", 32'(c_out_valid), 32'd0);
    c_sel = 2'd1;
    #1;
    chk("c_sel1_in_ready", 32'(c_in_ready), 32'b010);
    step();
    c_in_valid = 3'b000;
    chk("c_sel1_valid", 32'(c_out_valid), 32'd1);
    chk("c_sel1_data", 32'(c_out_data), 32'h22);
    chk("c_sel1_ch", 32'(c_out_ch), 32'd1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
